serial_to_vector_deser: RTL
===========================

# serial_to_vector_deser

Bit-serial to parallel deserializer that collects a framed serial bit stream into WIDTH-bit words. It presents each word on a valid/ready output port. It sits directly upstream of the vector bit-order stage and feeds it complete 8-bit vectors. The output is double-buffered so the serial side keeps shifting while a finished word waits for the consumer.

## Interface
- WIDTH, 8: word width in bits; legal range 2..32.
- MSB_FIRST, 0: 0 = first serial bit lands in vec_data[0]; 1 = first bit lands in vec_data[WIDTH-1].

- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- ser_valid  in  1  ser_bit/ser_sof are valid this cycle.
- ser_bit  in  1  serial data bit.
- ser_sof  in  1  marks the first bit of a frame.
- ser_ready  out  1  deserializer accepts a bit this cycle.
- vec_valid  out  1  vec_data holds a complete word.
- vec_data  out  WIDTH  assembled word.
- vec_ready  in  1  consumer accepts vec_data this cycle.
- frame_err  out  1  one-cycle pulse: frame restarted mid-word.

## Operation
- A bit is accepted when ser_valid && ser_ready. A word is transferred out when vec_valid && vec_ready.
- The FSM has three states:
  - IDLE: ser_ready=1. Accepted bits without ser_sof are discarded silently. A bit with ser_sof is stored as bit 0, count=1, and the FSM goes to SHIFT.
  - SHIFT: ser_ready=1. Each accepted bit is stored at position count, and count increments.
    - ser_sof on a bit with count≠0: discard the partial word, pulse frame_err, store this bit as bit 0, count=1.
    - ser_sof with count=0: legal, no error.
  - STALL: ser_ready=0. A completed word is parked in the hold register while the output register is occupied.
- Word completion: the accepted bit with count=WIDTH-1 completes the word and count wraps to 0.
  - If the output register is empty, or drains this same cycle, the word loads into the output register and the FSM stays in SHIFT.
  - Otherwise the word moves to the hold register and the FSM goes to STALL.
- STALL exit: when the output drains, the hold word loads into the output register and the FSM returns to SHIFT.
- After the first frame, words stream back-to-back with no ser_sof required.
- Bit placement: with MSB_FIRST=0, the k-th accepted bit of a word goes to vec_data[k]. With MSB_FIRST=1, it goes to vec_data[WIDTH-1-k].
- ser_ready is a function of state only. There is no combinational path from vec_ready to ser_ready.
- vec_data stays stable while vec_valid=1 and vec_ready=0.

## Timing
- Reset values: ser_ready=1 (IDLE), vec_valid=0, vec_data=0, frame_err=0, count=0, hold register empty.
- Reset mid-word or mid-STALL discards all partial, held and output data immediately.
- Latency: the final bit accepted in cycle N gives vec_valid=1 with the word in cycle N+1.
- Throughput: one bit per cycle. One word per WIDTH cycles is sustained when the consumer is always ready.
- frame_err is registered and asserts in cycle N+1 for an offending bit accepted in cycle N. It lasts exactly one cycle.
- STALL timing:
  - Entered in cycle N+1 after the completing bit in cycle N; ser_ready=0 from cycle N+1.
  - A drain in cycle M loads the held word so that vec_valid stays 1 with the new data in M+1, and ser_ready=1 in M+1.
- If the final bit and an output drain happen in the same cycle, vec_valid stays high continuously and the new data appears the next cycle.

## Structure
- Package deser_pkg holds:
  - the state typedef (IDLE, SHIFT, STALL, 2-bit encoding);
  - the default WIDTH constant;
  - the count width function, clog2(WIDTH).
- One sub-module, deser_shift_reg: a WIDTH-bit bit-insert register with a write-enable, a position index, a clear, and MSB_FIRST placement.
- The FSM, hold register and output register live in the top module.

## Test plan
- WIDTH=8, MSB_FIRST=0, vec_ready=1: send bits 1,0,1,1,0,0,1,0 with sof on the first. Expect vec_data=0x4D with vec_valid for one cycle, one cycle after the 8th bit.
- Same bits with MSB_FIRST=1: expect vec_data=0xB2.
- In IDLE, send 5 bits without sof: no vec_valid and no frame_err. Then send a sof frame carrying 0xFF (LSB first): expect vec_data=0xFF.
- Send sof plus 3 bits, then sof plus 8 bits encoding 0x3C: expect a single frame_err pulse one cycle after the second sof and exactly one word, 0x3C.
- Hold vec_ready=0 and stream two words, 0xA5 then 0x5A:
  - ser_ready drops after the second word completes, and vec_data stays at 0xA5.
  - Raise vec_ready for one cycle: expect vec_data=0x5A on the next cycle and ser_ready=1.
- Assert rst mid-STALL: expect vec_valid=0, vec_data=0 and ser_ready=1 immediately. A fresh frame then produces only new data.

Source files
------------

// File: rtl/deser_pkg.sv
// Shared types and constants for the serial-to-vector deserializer.
// Holds the FSM state encoding and the counter-width helper.
package deser_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        STALL = 2'd2
    } state_t;

    // Bits needed to index positions 0..width-1.
    function automatic int unsigned count_width(input int unsigned width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/deser_shift_reg.sv
// Bit-insert register: writes one serial bit at a given word position.
// Exposes the post-insert word so the caller can capture a completed word.
module deser_shift_reg
    import deser_pkg::*;
#(
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter bit          MSB_FIRST = 1'b0,
    localparam int unsigned CW       = count_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic             clear,
    input  logic [CW-1:0]    pos,
    input  logic             bit_in,
    output logic [WIDTH-1:0] word
);

    localparam logic [CW-1:0] TOP_POS = CW'(WIDTH - 1);

    logic [WIDTH-1:0] data;
    logic [CW-1:0]    phys;

    // NOTE: always_comb assigns every output a default first, so no path
    // through the block leaves a variable unassigned and no latch is inferred.
    always_comb begin
        phys = MSB_FIRST ? (TOP_POS - pos) : pos;
        word = clear ? '0 : data;
        if (wr_en) begin
            word[phys] = bit_in;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its inputs, independent of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data <= '0;
        end else if (wr_en || clear) begin
            data <= word;
        end
    end

endmodule

// File: rtl/serial_to_vector_deser.sv
// Framed bit-serial to WIDTH-bit word deserializer with a double-buffered
// valid/ready output (output register plus one hold register).
module serial_to_vector_deser
    import deser_pkg::*;
#(
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ser_valid,
    input  logic             ser_bit,
    input  logic             ser_sof,
    output logic             ser_ready,
    output logic             vec_valid,
    output logic [WIDTH-1:0] vec_data,
    input  logic             vec_ready,
    output logic             frame_err
);

    localparam int unsigned   CW       = count_width(WIDTH);
    localparam logic [CW-1:0] LAST_POS = CW'(WIDTH - 1);
    localparam logic [CW-1:0] ONE      = CW'(1);

    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("serial_to_vector_deser: WIDTH must be in 2..32");
    end

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] hold_data;
    logic [WIDTH-1:0] word;

    logic             accept;
    logic             drain;
    logic             sr_wr;
    logic             sr_clear;
    logic [CW-1:0]    sr_pos;

    // Ready depends on the state register only, so vec_ready never reaches it.
    assign ser_ready = (state != STALL);
    assign accept    = ser_valid && ser_ready;
    assign drain     = vec_valid && vec_ready;

    always_comb begin
        sr_wr    = 1'b0;
        sr_clear = 1'b0;
        sr_pos   = count;
        if (accept) begin
            if (ser_sof) begin
                sr_wr    = 1'b1;
                sr_clear = 1'b1;
                sr_pos   = '0;
            end else if (state == SHIFT) begin
                sr_wr = 1'b1;
            end
        end
    end

    deser_shift_reg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift_reg (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (sr_wr),
        .clear  (sr_clear),
        .pos    (sr_pos),
        .bit_in (ser_bit),
        .word   (word)
    );

    // NOTE: the hold and output registers are reset as well, so a reset in
    // the middle of a stall leaves no stale word visible on vec_data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            hold_data <= '0;
            vec_valid <= 1'b0;
            vec_data  <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            if (drain) begin
                vec_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (accept && ser_sof) begin
                        count <= ONE;
                        state <= SHIFT;
                    end
                end

                SHIFT: begin
                    if (accept) begin
                        if (ser_sof) begin
                            frame_err <= (count != '0);
                            count     <= ONE;
                        end else if (count == LAST_POS) begin
                            count <= '0;
                            if (!vec_valid || vec_ready) begin
                                vec_data  <= word;
                                vec_valid <= 1'b1;
                            end else begin
                                hold_data <= word;
                                state     <= STALL;
                            end
                        end else begin
                            count <= count + ONE;
                        end
                    end
                end

                STALL: begin
                    // Output is always occupied here; a drain promotes the held word.
                    if (vec_ready) begin
                        vec_data  <= hold_data;
                        vec_valid <= 1'b1;
                        state     <= SHIFT;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
